uop_nand_sequencer: RTL and testbench
=====================================

// Module: uop_nand_sequencer
// PURPOSE
//  Multi-cycle logic unit that builds NAND, AND, OR and XOR from one shared
//  WIDTH-bit bitwise 2-input NAND (z = ~(x & y)).
//  An FSM steps operand muxes and scratch registers through one NAND per clock.
//  Teaching demo: how a controller sequences a single combinational resource.
// PARAMETERS
//  WIDTH   8   operand/result width in bits
//  CNTW    16  width of the NAND-use counter (saturating)
// PORTS
//  clk        in   1      clock, rising edge
//  n_reset    in   1      asynchronous, active-low reset
//  start      in   1      request; sampled on rising edge when state != EXEC
//  op         in   2      00=NAND 01=AND 10=OR 11=XOR; captured with start
//  a          in   WIDTH  operand A; captured with start
//  b          in   WIDTH  operand B; captured with start
//  busy       out  1      high while state == EXEC
//  done       out  1      one-cycle pulse: result valid (state == DONE)
//  result     out  WIDTH  registered result; held until the next completion
//  nand_uses  out  CNTW   count of NAND evaluations since reset; saturates
// BEHAVIOUR
//  - Reset (n_reset=0, any time, async): state=IDLE; busy=0, done=0,
//    result=0, nand_uses=0; scratch/operand registers=0.
//    Reset mid-EXEC aborts the operation; no done pulse follows.
//  - States: IDLE, EXEC, DONE.
//    IDLE/DONE + start=1 -> EXEC: capture ra=a, rb=b, rop=op, step=0.
//    IDLE + start=0 -> IDLE.  DONE + start=0 -> IDLE.
//    EXEC: one NAND per cycle; after last step -> DONE.
//    DONE lasts exactly one cycle unless start=1 (back-to-back accepted).
//  - start while EXEC is ignored; operands are not re-sampled.
//  - Datapath: one nand = ~(x & y); x,y muxed by (rop,step):
//    NAND: s0: result=nand(ra,rb)                                  1 step
//    AND : s0: t0=nand(ra,rb); s1: result=nand(t0,t0)              2 steps
//    OR  : s0: t0=nand(ra,ra); s1: t1=nand(rb,rb);
//          s2: result=nand(t0,t1)                                  3 steps
//    XOR : s0: t0=nand(ra,rb); s1: t1=nand(ra,t0);
//          s2: rb=nand(rb,t0); s3: result=nand(t1,rb)              4 steps
//  - Only the NAND cell computes logic; no other bitwise operators in datapath.
//  - Latency: start sampled at edge E0 -> done=1 in the cycle after edge En,
//    n = step count above. busy=1 for exactly n cycles.
//  - result updates only on the final-step edge; stable in IDLE and EXEC.
//  - nand_uses increments by 1 on every EXEC edge. At 2^CNTW-1 it holds.
//  - step counter is 2 bits; it never wraps inside an operation
//    (max 4 steps: 0..3).
//  - Unused op encodings: none; all 4 values defined.
// TESTING (WIDTH=8, a=8'hCC, b=8'hAA unless noted)
//  1 op=00 start 1 cycle -> busy 1 cycle, done next cycle,
//    result=8'h77, nand_uses=1
//  2 op=01/10/11 -> result 8'h88/8'hEE/8'h66, busy 2/3/4 cycles,
//    nand_uses cumulative 3/6/10
//  3 start=1 with op=11 held during EXEC, a/b changed to 8'h00 ->
//    no restart; result=8'h66
//  4 start asserted in DONE cycle (op=00, a=8'hFF, b=8'h0F) ->
//    re-enter EXEC, no IDLE cycle; result=8'hF0
//  5 n_reset low during XOR step 2 -> busy=0, done=0, result=0,
//    nand_uses=0 immediately; no done after release
//  6 CNTW=4: run 5 XORs (20 NANDs) -> nand_uses saturates at 4'hF

Source files
------------

// File: rtl/uop_nand_sequencer.sv
// Multi-cycle logic unit: NAND/AND/OR/XOR built by sequencing one shared
// WIDTH-bit NAND cell, one evaluation per clock, under a three-state FSM.
module uop_nand_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [CNTW-1:0]  nand_uses
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] ra, rb, t0, t1;
   logic [1:0]       rop, step;
   logic [WIDTH-1:0] nand_x, nand_y, nand_z;
   logic             accept, last_step;
   logic             wr_t0, wr_t1, wr_rb, wr_res;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      if (&v) return v;
      return v + {{(CNTW-1){1'b0}}, 1'b1};
   endfunction

   // The only logic-computing element in the datapath.
   assign nand_z = ~(nand_x & nand_y);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = EXEC;
         EXEC:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = start ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Step count is rop+1, so the final step is the one where step equals rop.
   always_comb begin
      busy      = (state == EXEC);
      done      = (state == DONE);
      accept    = start && (state != EXEC);
      last_step = (state == EXEC) && (step == rop);
      nand_x    = ra;
      nand_y    = rb;
      wr_t0     = 1'b0;
      wr_t1     = 1'b0;
      wr_rb     = 1'b0;
      wr_res    = 1'b0;
      case ({rop, step})
         4'b01_01: begin nand_x = t0; nand_y = t0; end
         4'b10_00: begin nand_x = ra; nand_y = ra; end
         4'b10_01: begin nand_x = rb; nand_y = rb; end
         4'b10_10: begin nand_x = t0; nand_y = t1; end
         4'b11_01: begin nand_x = ra; nand_y = t0; end
         4'b11_10: begin nand_x = rb; nand_y = t0; end
         4'b11_11: begin nand_x = t1; nand_y = rb; end
         default:  begin nand_x = ra; nand_y = rb; end
      endcase
      if (state == EXEC) begin
         if (last_step)                                      wr_res = 1'b1;
         else if ({rop, step} == 4'b10_01 || {rop, step} == 4'b11_01) wr_t1 = 1'b1;
         else if ({rop, step} == 4'b11_10)                   wr_rb  = 1'b1;
         else                                                wr_t0  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         ra        <= '0;
         rb        <= '0;
         t0        <= '0;
         t1        <= '0;
         rop       <= 2'd0;
         step      <= 2'd0;
         result    <= '0;
         nand_uses <= '0;
      end else begin
         if (accept) begin
            ra   <= a;
            rb   <= b;
            rop  <= op;
            step <= 2'd0;
         end else if (state == EXEC) begin
            if (!last_step) step <= step + 2'd1;
            if (wr_t0)  t0     <= nand_z;
            if (wr_t1)  t1     <= nand_z;
            if (wr_rb)  rb     <= nand_z;
            if (wr_res) result <= nand_z;
         end
         if (state == EXEC) nand_uses <= sat_inc(nand_uses);
      end
   end

endmodule

// File: tb/tb_uop_nand_sequencer.sv
// Bench for uop_nand_sequencer: table vectors, hand corner sequences and random
// operations against a plain-arithmetic reference; a CNTW=4 copy checks saturation.
module tb_uop_nand_sequencer;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        start;
   logic [1:0]  op;
   logic [7:0]  a, b;
   logic        busy, done, busy_s, done_s;
   logic [7:0]  result, result_s;
   logic [15:0] nand_uses;
   logic [3:0]  nand_uses_s;

   int n_tests = 0;
   int n_fail  = 0;
   int uses_m  = 0;

   always #5 clk = ~clk;

   uop_nand_sequencer #(.WIDTH(8), .CNTW(16)) u_dut (
      .clk(clk), .n_reset(n_reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .nand_uses(nand_uses));

   uop_nand_sequencer #(.WIDTH(8), .CNTW(4)) u_sat (
      .clk(clk), .n_reset(n_reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy_s), .done(done_s), .result(result_s), .nand_uses(nand_uses_s));

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_res;
      int         exp_busy;
   } vec_t;

   function automatic logic [7:0] ref_res(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         2'd0:    return ~(x & y);
         2'd1:    return x & y;
         2'd2:    return x | y;
         default: return x ^ y;
      endcase
   endfunction

   function automatic int ref_steps(input logic [1:0] o);
      case (o)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_uses(input string tag);
      check($sformatf("%s uses", tag), 32'(nand_uses), 32'(sat(uses_m, 65535)));
      check($sformatf("%s uses_sat", tag), 32'(nand_uses_s), 32'(sat(uses_m, 15)));
   endtask

   // One isolated operation: start for one cycle, then wait (bounded) for done.
   task automatic run_and_check(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] exp_res, input int exp_busy, input string tag);
      int bc;
      bit seen;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      bc = 0; seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) bc++;
            @(negedge clk);
         end
      end
      uses_m += ref_steps(o);
      check($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
      check($sformatf("%s busy_cycles", tag), 32'(bc), 32'(exp_busy));
      check($sformatf("%s result", tag), 32'(result), 32'(exp_res));
      check($sformatf("%s result_sat", tag), 32'(result_s), 32'(exp_res));
      check_uses(tag);
      @(negedge clk);
      check($sformatf("%s done_one_cycle", tag), 32'(done), 32'd0);
   endtask

   task automatic wait_done(input string tag, output int bc);
      bit seen;
      bc = 0; seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) bc++;
            @(negedge clk);
         end
      end
      check($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
   endtask

   vec_t vecs[8];

   initial begin
      int bc;
      logic [1:0] ro;
      logic [7:0] rx, ry;
      bit active;

      vecs[0] = '{2'd0, 8'hCC, 8'hAA, 8'h77, 1};
      vecs[1] = '{2'd1, 8'hCC, 8'hAA, 8'h88, 2};
      vecs[2] = '{2'd2, 8'hCC, 8'hAA, 8'hEE, 3};
      vecs[3] = '{2'd3, 8'hCC, 8'hAA, 8'h66, 4};
      vecs[4] = '{2'd3, 8'hFF, 8'hFF, 8'h00, 4};
      vecs[5] = '{2'd2, 8'h00, 8'h00, 8'h00, 3};
      vecs[6] = '{2'd1, 8'hFF, 8'hF0, 8'hF0, 2};
      vecs[7] = '{2'd0, 8'h00, 8'h5A, 8'hFF, 1};

      n_reset = 1'b0; start = 1'b0; op = 2'd0; a = 8'h00; b = 8'h00;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset uses", 32'(nand_uses), 32'd0);
      n_reset = 1'b1;

      for (int i = 0; i < 8; i++)
         run_and_check(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_busy,
                       $sformatf("vec%0d", i));

      // start held through EXEC with operands changing: no restart, no re-sample
      @(negedge clk);
      start = 1'b1; op = 2'd3; a = 8'hCC; b = 8'hAA;
      @(negedge clk);
      a = 8'h00; b = 8'h00;
      wait_done("hold", bc);
      start = 1'b0;
      uses_m += 4;
      check("hold busy_cycles", 32'(bc), 32'd4);
      check("hold result", 32'(result), 32'h66);
      check_uses("hold");
      @(negedge clk);
      check("hold idle_after", 32'(busy), 32'd0);

      // back-to-back: new start during the DONE cycle
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 8'hCC; b = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      wait_done("b2b first", bc);
      check("b2b first result", 32'(result), 32'h77);
      start = 1'b1; op = 2'd0; a = 8'hFF; b = 8'h0F;
      @(negedge clk);
      check("b2b no_idle busy", 32'(busy), 32'd1);
      start = 1'b0;
      @(negedge clk);
      check("b2b second done", 32'(done), 32'd1);
      check("b2b second result", 32'(result), 32'hF0);
      uses_m += 2;
      check_uses("b2b");
      @(negedge clk);

      // asynchronous reset during XOR step 2
      @(negedge clk);
      start = 1'b1; op = 2'd3; a = 8'hCC; b = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_reset = 1'b0;
      #1;
      uses_m = 0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort result", 32'(result), 32'd0);
      check_uses("abort");
      @(negedge clk);
      n_reset = 1'b1;
      active = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) active = 1'b1;
      end
      check("abort no_done_after", 32'(active), 32'd0);

      // five XORs: the CNTW=4 copy must stop at 4'hF
      for (int i = 0; i < 5; i++)
         run_and_check(2'd3, 8'hCC, 8'hAA, 8'h66, 4, $sformatf("sat%0d", i));
      check("sat final", 32'(nand_uses_s), 32'hF);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = 8'($urandom);
         ry = 8'($urandom);
         run_and_check(ro, rx, ry, ref_res(ro, rx, ry), ref_steps(ro), $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
